// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: pipeline write, long-unit result handshake, issue marks, decode reads, RF write drive.
// master = surrounding core, slave = rf_wb_arbiter.
interface rf_wb_arbiter_if;
  logic        pipe_wen;
  logic [4:0]  pipe_waddr;
  logic [3:0]  pipe_wbytes;
  logic [31:0] pipe_wdata;
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        issue_valid;
  logic [4:0]  issue_waddr;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        busy_stall;
  logic        pipe_hold;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [3:0]  rf_wbytes;
  logic [31:0] rf_wdata;

  modport master (
    output pipe_wen, pipe_waddr, pipe_wbytes, pipe_wdata,
    output lu_valid, lu_waddr, lu_wdata,
    output issue_valid, issue_waddr, raddr1, raddr2,
    input  lu_ready, busy_stall, pipe_hold,
    input  rf_wen, rf_waddr, rf_wbytes, rf_wdata
  );

  modport slave (
    input  pipe_wen, pipe_waddr, pipe_wbytes, pipe_wdata,
    input  lu_valid, lu_waddr, lu_wdata,
    input  issue_valid, issue_waddr, raddr1, raddr2,
    output lu_ready, busy_stall, pipe_hold,
    output rf_wen, rf_waddr, rf_wbytes, rf_wdata
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Single RF write port shared by the pipeline and a 2-deep long-unit result FIFO plus busy scoreboard; zero-latency grant.
// Pipeline wins unless RF_WB_STARVE_EN is defined and a queued result has waited STARVE_LIMIT cycles (pipe_hold).
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           reset,
  rf_wb_arbiter_if.slave bus
);
  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } lu_ent_t;

  lu_ent_t     fifo_mem [2];
  lu_ent_t     head;
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic [31:0] sb, sb_set, sb_clr;
  logic        fifo_nempty, push, pop, hold;

  assign fifo_nempty  = (count != 2'd0);
  assign head         = fifo_mem[rd_ptr];
  assign bus.lu_ready = !reset && (count < 2'd2);
  assign push         = bus.lu_valid && bus.lu_ready;

`ifdef RF_WB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1) + 1;
  logic [CW-1:0] starve_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve_cnt <= '0;
    else if (!fifo_nempty || pop)
      starve_cnt <= '0;
    else if (starve_cnt < CW'(STARVE_LIMIT))
      starve_cnt <= starve_cnt + CW'(1);
  end

  assign hold = !reset && (starve_cnt >= CW'(STARVE_LIMIT));
`else
  assign hold = 1'b0;
`endif

  assign bus.pipe_hold = hold;
  // Under hold the head wins even if the pipeline (illegally) still presents a write.
  assign pop = !reset && fifo_nempty && (hold || !bus.pipe_wen);

  always_comb begin
    bus.rf_wen    = 1'b0;
    bus.rf_waddr  = '0;
    bus.rf_wbytes = '0;
    bus.rf_wdata  = '0;
    if (pop) begin
      bus.rf_wen    = 1'b1;
      bus.rf_waddr  = head.waddr;
      bus.rf_wbytes = 4'hF;
      bus.rf_wdata  = head.wdata;
    end else if (!reset && bus.pipe_wen) begin
      bus.rf_wen    = 1'b1;
      bus.rf_waddr  = bus.pipe_waddr;
      bus.rf_wbytes = bus.pipe_wbytes;
      bus.rf_wdata  = bus.pipe_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{waddr: bus.lu_waddr, wdata: bus.lu_wdata};
  end

  // Set is OR-ed in after the clear so a re-issue to the retiring register stays busy.
  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (bus.issue_valid && (bus.issue_waddr != 5'd0)) sb_set[bus.issue_waddr] = 1'b1;
    if (pop) sb_clr[head.waddr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sb <= '0;
    else       sb <= (sb & ~sb_clr) | sb_set;
  end

  assign bus.busy_stall = !reset &&
                          (((bus.raddr1 != 5'd0) && sb[bus.raddr1]) ||
                           ((bus.raddr2 != 5'd0) && sb[bus.raddr2]));
endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rf_wb_arbiter_if bus();
  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        pw;  logic [4:0] pa; logic [3:0] pb; logic [31:0] pd;
    logic        lv;  logic [4:0] la; logic [31:0] ld;
    logic        iv;  logic [4:0] ia;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        e_wen; logic [4:0] e_addr; logic [3:0] e_bytes; logic [31:0] e_data;
    logic        e_busy; logic e_rdy;
  } vec_t;

  vec_t vecs [15];

  task automatic drive(input vec_t v);
    bus.pipe_wen    = v.pw; bus.pipe_waddr = v.pa; bus.pipe_wbytes = v.pb; bus.pipe_wdata = v.pd;
    bus.lu_valid    = v.lv; bus.lu_waddr   = v.la; bus.lu_wdata    = v.ld;
    bus.issue_valid = v.iv; bus.issue_waddr = v.ia;
    bus.raddr1      = v.r1; bus.raddr2     = v.r2;
  endtask

  task automatic drv(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                     input logic lv, input logic [4:0] la, input logic [31:0] ld,
                     input logic iv, input logic [4:0] ia, input logic [4:0] r1);
    vec_t v;
    v = '{pw, pa, 4'h3, pd, lv, la, ld, iv, ia, r1, 5'd0, 1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 1'b0};
    drive(v);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference scoreboard: queued LU results, busy bits and starve count, advanced at each negedge.
  logic [4:0]  mq_a [$];
  logic [31:0] mq_d [$];
  logic [31:0] msb = '0;
  int          mcnt = 0;
  logic        m_pop, m_hold, m_busy, m_rdy;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_wen",   bus.rf_wen,     0);
      chk("rst_waddr", bus.rf_waddr,   0);
      chk("rst_wdata", bus.rf_wdata,   0);
      chk("rst_rdy",   bus.lu_ready,   0);
      chk("rst_busy",  bus.busy_stall, 0);
      chk("rst_hold",  bus.pipe_hold,  0);
      mq_a.delete();
      mq_d.delete();
      msb  = '0;
      mcnt = 0;
    end else begin
      m_hold = 1'b0;
`ifdef RF_WB_STARVE_EN
      m_hold = (mcnt >= LIMIT);
`endif
      m_rdy  = (mq_a.size() < 2);
      m_pop  = (mq_a.size() != 0) && (!bus.pipe_wen || m_hold);
      m_busy = ((bus.raddr1 != 0) && msb[bus.raddr1]) || ((bus.raddr2 != 0) && msb[bus.raddr2]);
      chk("sb_hold", bus.pipe_hold,  m_hold);
      chk("sb_rdy",  bus.lu_ready,   m_rdy);
      chk("sb_busy", bus.busy_stall, m_busy);
      if (m_pop) begin
        chk("sb_lu_wen",   bus.rf_wen,    1);
        chk("sb_lu_addr",  bus.rf_waddr,  mq_a[0]);
        chk("sb_lu_bytes", bus.rf_wbytes, 4'hF);
        chk("sb_lu_data",  bus.rf_wdata,  mq_d[0]);
      end else if (bus.pipe_wen) begin
        chk("sb_p_wen",   bus.rf_wen,    1);
        chk("sb_p_addr",  bus.rf_waddr,  bus.pipe_waddr);
        chk("sb_p_bytes", bus.rf_wbytes, bus.pipe_wbytes);
        chk("sb_p_data",  bus.rf_wdata,  bus.pipe_wdata);
      end else begin
        chk("sb_idle_wen",  bus.rf_wen,   0);
        chk("sb_idle_addr", bus.rf_waddr, 0);
        chk("sb_idle_data", bus.rf_wdata, 0);
      end
      if ((mq_a.size() != 0) && !m_pop) mcnt++;
      else mcnt = 0;
      if (m_pop) begin
        msb[mq_a[0]] = 1'b0;
        void'(mq_a.pop_front());
        void'(mq_d.pop_front());
      end
      if (bus.issue_valid && (bus.issue_waddr != 0)) msb[bus.issue_waddr] = 1'b1;
      if (bus.lu_valid && m_rdy) begin
        mq_a.push_back(bus.lu_waddr);
        mq_d.push_back(bus.lu_wdata);
      end
    end
  end

  initial begin
    //          pw pa    pb    pd             lv la    ld             iv ia    r1    r2     wen addr  bytes data           busy rdy
    vecs[0]  = '{0, 5'd0, 4'h0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd0, 5'd0,  0, 5'd0, 4'h0, 32'h0,         0, 1};
    vecs[1]  = '{1, 5'd5, 4'h3, 32'h1234_5678, 0, 5'd0, 32'h0,         0, 5'd0, 5'd0, 5'd0,  1, 5'd5, 4'h3, 32'h1234_5678, 0, 1};
    vecs[2]  = '{1, 5'd2, 4'hF, 32'hAAAA,      0, 5'd0, 32'h0,         1, 5'd7, 5'd7, 5'd0,  1, 5'd2, 4'hF, 32'hAAAA,      0, 1};
    vecs[3]  = '{1, 5'd3, 4'h1, 32'h3333,      1, 5'd7, 32'hDEAD_BEEF, 0, 5'd0, 5'd7, 5'd0,  1, 5'd3, 4'h1, 32'h3333,      1, 1};
    vecs[4]  = '{1, 5'd4, 4'h2, 32'h4444,      0, 5'd0, 32'h0,         0, 5'd0, 5'd7, 5'd0,  1, 5'd4, 4'h2, 32'h4444,      1, 1};
    vecs[5]  = '{1, 5'd6, 4'h4, 32'h6666,      0, 5'd0, 32'h0,         0, 5'd0, 5'd7, 5'd0,  1, 5'd6, 4'h4, 32'h6666,      1, 1};
    vecs[6]  = '{0, 5'd0, 4'h0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd7, 5'd0,  1, 5'd7, 4'hF, 32'hDEAD_BEEF, 1, 1};
    vecs[7]  = '{0, 5'd0, 4'h0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd7, 5'd0,  0, 5'd0, 4'h0, 32'h0,         0, 1};
    vecs[8]  = '{0, 5'd0, 4'h0, 32'h0,         0, 5'd0, 32'h0,         1, 5'd9, 5'd0, 5'd9,  0, 5'd0, 4'h0, 32'h0,         0, 1};
    vecs[9]  = '{0, 5'd0, 4'h0, 32'h0,         1, 5'd9, 32'h99,        0, 5'd0, 5'd0, 5'd9,  0, 5'd0, 4'h0, 32'h0,         1, 1};
    vecs[10] = '{0, 5'd0, 4'h0, 32'h0,         0, 5'd0, 32'h0,         1, 5'd9, 5'd0, 5'd9,  1, 5'd9, 4'hF, 32'h99,        1, 1};
    vecs[11] = '{0, 5'd0, 4'h0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd0, 5'd9,  0, 5'd0, 4'h0, 32'h0,         1, 1};
    vecs[12] = '{0, 5'd0, 4'h0, 32'h0,         1, 5'd9, 32'h1,         0, 5'd0, 5'd0, 5'd9,  0, 5'd0, 4'h0, 32'h0,         1, 1};
    vecs[13] = '{0, 5'd0, 4'h0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd0, 5'd9,  1, 5'd9, 4'hF, 32'h1,         1, 1};
    vecs[14] = '{0, 5'd0, 4'h0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd0, 5'd9,  0, 5'd0, 4'h0, 32'h0,         0, 1};

    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Vector table: pass-through, contention on r7, set/clear collision on r9.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_wen", i),   bus.rf_wen,     vecs[i].e_wen);
      chk($sformatf("v%0d_addr", i),  bus.rf_waddr,   vecs[i].e_addr);
      chk($sformatf("v%0d_bytes", i), bus.rf_wbytes,  vecs[i].e_bytes);
      chk($sformatf("v%0d_data", i),  bus.rf_wdata,   vecs[i].e_data);
      chk($sformatf("v%0d_busy", i),  bus.busy_stall, vecs[i].e_busy);
      chk($sformatf("v%0d_rdy", i),   bus.lu_ready,   vecs[i].e_rdy);
      next_cycle();
    end

    // Full FIFO: r1,r2 fill it under pipeline writes, r3 waits for a pop.
    drv(1, 10, 32'hA0, 1, 1, 32'h11, 0, 0, 0); @(negedge clk); chk("full_a_rdy", bus.lu_ready, 1); next_cycle();
    drv(1, 10, 32'hA0, 1, 2, 32'h22, 0, 0, 0); @(negedge clk); chk("full_b_rdy", bus.lu_ready, 1); next_cycle();
    drv(1, 10, 32'hA0, 1, 3, 32'h33, 0, 0, 0); @(negedge clk); chk("full_c_rdy", bus.lu_ready, 0); next_cycle();
    @(negedge clk); chk("full_d_rdy", bus.lu_ready, 0); chk("full_d_addr", bus.rf_waddr, 10); next_cycle();
    drv(0, 0, 0, 1, 3, 32'h33, 0, 0, 0);
    @(negedge clk); chk("full_e_addr", bus.rf_waddr, 1); chk("full_e_data", bus.rf_wdata, 32'h11);
    chk("full_e_rdy", bus.lu_ready, 0); next_cycle();
    @(negedge clk); chk("full_f_addr", bus.rf_waddr, 2); chk("full_f_rdy", bus.lu_ready, 1); next_cycle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("full_g_addr", bus.rf_waddr, 3); chk("full_g_data", bus.rf_wdata, 32'h33); next_cycle();
    @(negedge clk); chk("full_h_wen", bus.rf_wen, 0); next_cycle();

    // Starvation: one queued result against continuous pipeline writes.
    drv(1, 11, 32'hB0, 1, 4, 32'h44, 0, 0, 0); next_cycle();
    drv(1, 11, 32'hB0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      logic exp_hold;
      logic [4:0] exp_addr;
      exp_hold = 1'b0;
      exp_addr = 5'd11;
`ifdef RF_WB_STARVE_EN
      if (k == LIMIT + 1) begin
        exp_hold = 1'b1;
        exp_addr = 5'd4;
      end
`endif
      @(negedge clk);
      chk($sformatf("starve_w%0d_hold", k), bus.pipe_hold, exp_hold);
      chk($sformatf("starve_w%0d_addr", k), bus.rf_waddr,  exp_addr);
      next_cycle();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef RF_WB_STARVE_EN
    chk("starve_after_wen", bus.rf_wen, 0);
`else
    chk("starve_drain_addr", bus.rf_waddr, 4);
`endif
    next_cycle();

    // Async reset with two queued entries and r3 busy.
    drv(0, 0, 0, 0, 0, 0, 1, 3, 0); next_cycle();
    drv(1, 12, 32'hC0, 1, 5, 32'h55, 0, 0, 3); next_cycle();
    drv(1, 12, 32'hC0, 1, 6, 32'h66, 0, 0, 3); next_cycle();
    drv(1, 12, 32'hC0, 0, 0, 0, 0, 0, 3);
    @(negedge clk); chk("pre_rst_busy", bus.busy_stall, 1); chk("pre_rst_rdy", bus.lu_ready, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_now_wen",  bus.rf_wen,     0);
    chk("rst_now_busy", bus.busy_stall, 0);
    chk("rst_now_rdy",  bus.lu_ready,   0);
    @(posedge clk);
    #1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 3);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy",  bus.lu_ready,   1);
    chk("post_rst_wen",  bus.rf_wen,     0);
    chk("post_rst_busy", bus.busy_stall, 0);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
